mont_exp_sequencer: RTL

//  Control FSM for left-to-right square-and-multiply modular exponentiation.

---
 rtl/mont_exp_pkg.sv | 32 +++
 rtl/exp_bit_scanner.sv | 55 +++++
 rtl/mont_exp_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mont_exp_pkg.sv
// mont_exp_pkg
//   Shared definitions for the Montgomery exponentiation sequencer:
//   multiplier operand codes, FSM state encoding and the exp_len width helper.
package mont_exp_pkg;

  // Operand codes driven on mm_opa_sel / mm_opb_sel
  localparam logic [2:0] OPND_A   = 3'd0;
  localparam logic [2:0] OPND_XT  = 3'd1;
  localparam logic [2:0] OPND_X   = 3'd2;
  localparam logic [2:0] OPND_R2  = 3'd3;
  localparam logic [2:0] OPND_ONE = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_PRE_ISS   = 4'd1,
    ST_PRE_WAIT  = 4'd2,
    ST_LOAD_A    = 4'd3,
    ST_SQR_ISS   = 4'd4,
    ST_SQR_WAIT  = 4'd5,
    ST_MUL_ISS   = 4'd6,
    ST_MUL_WAIT  = 4'd7,
    ST_POST_ISS  = 4'd8,
    ST_POST_WAIT = 4'd9,
    ST_FIN       = 4'd10
  } state_t;

  // Width needed to hold a bit count of 0..exp_w
  function automatic int exp_len_width(input int exp_w);
    return $clog2(exp_w + 1);
  endfunction

endpackage

// File: rtl/exp_bit_scanner.sv
// exp_bit_scanner
//   Latched copy of the exponent plus a down-counter of bits still to scan.
//   On load the significant bits are left-aligned so the MSB of the window
//   (bit exp_len-1) sits at the top; each step shifts the next bit up.
// Ports
//   clk, resetn   clock, async active-low reset
//   load          latch exponent / exp_len
//   step          consume the current bit
//   exponent      exponent value (bits at and above exp_len ignored)
//   exp_len       number of significant bits
//   cur_bit       exponent bit currently being processed
//   last_bit      current bit is the final one (counter == 1)
//   empty         no bits to scan (counter == 0)
module exp_bit_scanner
  import mont_exp_pkg::*;
#(
  parameter int EXP_W = 1024,
  parameter int LEN_W = exp_len_width(EXP_W)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             step,
  input  logic [EXP_W-1:0] exponent,
  input  logic [LEN_W-1:0] exp_len,
  output logic             cur_bit,
  output logic             last_bit,
  output logic             empty
);

  logic [EXP_W-1:0] shreg;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] align;

  // Shifting by EXP_W-exp_len also discards the don't-care upper bits.
  assign align = LEN_W'(EXP_W) - exp_len;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg     <= '0;
      remaining <= '0;
    end else if (load) begin
      shreg     <= exponent << align;
      remaining <= exp_len;
    end else if (step && (remaining != '0)) begin
      shreg     <= shreg << 1;
      remaining <= remaining - 1'b1;
    end
  end

  assign cur_bit  = shreg[EXP_W-1];
  assign last_bit = (remaining == LEN_W'(1));
  assign empty    = (remaining == '0);

endmodule

// File: rtl/mont_exp_sequencer.sv
// mont_exp_sequencer
//   Control FSM for left-to-right square-and-multiply modular exponentiation
//   around one shared Montgomery multiplier (start/done handshake).
// Ports
//   clk, resetn          clock, async active-low reset
//   start                request (level), sampled only in IDLE
//   exponent, exp_len    exponent and number of significant bits
//   mm_start / mm_done   multiplier launch pulse / result-valid pulse
//   mm_opa_sel/opb_sel   registered operand codes (OPND_*)
//   wr_xt, wr_a          load X~ / A from the multiplier result
//   ld_a_rmodm           load A with R mod m
//   busy, done           operation in flight / completion pulse
//
// state     | meaning
// IDLE      | waiting for start
// PRE_ISS   | launch X~ = MM(X, R2)
// PRE_WAIT  | wait for X~, write it
// LOAD_A    | A = R mod m
// SQR_ISS   | launch A = MM(A, A)
// SQR_WAIT  | wait for square, write A
// MUL_ISS   | launch A = MM(A, X~) for a 1 bit
// MUL_WAIT  | wait for multiply, write A
// POST_ISS  | launch A = MM(A, 1) to leave Montgomery form
// POST_WAIT | wait for final result, write A
// FIN       | done pulse
module mont_exp_sequencer
  import mont_exp_pkg::*;
#(
  parameter int EXP_W = 1024,
  parameter int LEN_W = exp_len_width(EXP_W)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [EXP_W-1:0] exponent,
  input  logic [LEN_W-1:0] exp_len,
  output logic             mm_start,
  input  logic             mm_done,
  output logic [2:0]       mm_opa_sel,
  output logic [2:0]       mm_opb_sel,
  output logic             wr_xt,
  output logic             wr_a,
  output logic             ld_a_rmodm,
  output logic             busy,
  output logic             done
);

  state_t state_r, state_nx;
  logic   scan_load, scan_step;
  logic   cur_bit, last_bit, scan_empty;

  exp_bit_scanner #(
    .EXP_W(EXP_W),
    .LEN_W(LEN_W)
  ) u_scanner (
    .clk      (clk),
    .resetn   (resetn),
    .load     (scan_load),
    .step     (scan_step),
    .exponent (exponent),
    .exp_len  (exp_len),
    .cur_bit  (cur_bit),
    .last_bit (last_bit),
    .empty    (scan_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= ST_IDLE;
    else         state_r <= state_nx;
  end

  always_comb begin
    state_nx  = state_r;
    scan_load = 1'b0;
    scan_step = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          scan_load = 1'b1;
          state_nx  = ST_PRE_ISS;
        end
      end
      ST_PRE_ISS:  state_nx = ST_PRE_WAIT;
      ST_PRE_WAIT: if (mm_done) state_nx = ST_LOAD_A;
      ST_LOAD_A:   state_nx = scan_empty ? ST_POST_ISS : ST_SQR_ISS;
      ST_SQR_ISS:  state_nx = ST_SQR_WAIT;
      ST_SQR_WAIT: begin
        if (mm_done) begin
          if (cur_bit) begin
            state_nx = ST_MUL_ISS;
          end else begin
            scan_step = 1'b1;
            state_nx  = last_bit ? ST_POST_ISS : ST_SQR_ISS;
          end
        end
      end
      ST_MUL_ISS:  state_nx = ST_MUL_WAIT;
      ST_MUL_WAIT: begin
        if (mm_done) begin
          scan_step = 1'b1;
          state_nx  = last_bit ? ST_POST_ISS : ST_SQR_ISS;
        end
      end
      ST_POST_ISS:  state_nx = ST_POST_WAIT;
      ST_POST_WAIT: if (mm_done) state_nx = ST_FIN;
      ST_FIN:       state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  // Selects load on entry to an *_ISS state and hold until the next issue,
  // so they are stable from mm_start through mm_done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mm_opa_sel <= OPND_A;
      mm_opb_sel <= OPND_A;
    end else begin
      case (state_nx)
        ST_PRE_ISS: begin
          mm_opa_sel <= OPND_X;
          mm_opb_sel <= OPND_R2;
        end
        ST_SQR_ISS: begin
          mm_opa_sel <= OPND_A;
          mm_opb_sel <= OPND_A;
        end
        ST_MUL_ISS: begin
          mm_opa_sel <= OPND_A;
          mm_opb_sel <= OPND_XT;
        end
        ST_POST_ISS: begin
          mm_opa_sel <= OPND_A;
          mm_opb_sel <= OPND_ONE;
        end
        default: begin
          mm_opa_sel <= mm_opa_sel;
          mm_opb_sel <= mm_opb_sel;
        end
      endcase
    end
  end

  always_comb begin
    mm_start   = 1'b0;
    wr_xt      = 1'b0;
    wr_a       = 1'b0;
    ld_a_rmodm = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_r)
      ST_IDLE:      busy = 1'b0;
      ST_PRE_ISS,
      ST_SQR_ISS,
      ST_MUL_ISS,
      ST_POST_ISS:  mm_start = 1'b1;
      ST_PRE_WAIT:  wr_xt = mm_done;
      ST_SQR_WAIT,
      ST_MUL_WAIT,
      ST_POST_WAIT: wr_a = mm_done;
      ST_LOAD_A:    ld_a_rmodm = 1'b1;
      ST_FIN: begin
        done = 1'b1;
        busy = 1'b0;
      end
      default:      busy = 1'b0;
    endcase
  end

endmodule
